cache_mem_arbiter: RTL

Two-port arbiter that shares the single physical-memory bus between the instruction-cache and data-cache controllers. Each cache controller's miss path (allocate, write-back) sees a private memory port. The arbiter grants exactly one requester at a time, using round-robin, and steers `cyc`/`stb`/`we`/address/data toward memory and `ack`/`rty`/read data back.

---
 rtl/cache_mem_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one memory bus between the I-cache and D-cache miss ports.
// Optional watchdog enabled by defining CACHE_ARB_TIMEOUT_EN.
module cache_mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 256,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_cyc,
  input  logic                  i_stb,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  i_ack,
  output logic                  i_rty,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_cyc,
  input  logic                  d_stb,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ack,
  output logic                  d_rty,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_cyc,
  output logic                  mem_stb,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic                  mem_rty,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  // state   | meaning
  // IDLE    | bus parked, outputs 0, arbitrating on cyc & stb
  // GRANT_I | I-cache owns the bus until it drops cyc
  // GRANT_D | D-cache owns the bus until it drops cyc
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t state_q;
  logic   last_grant_q;
  logic   i_req;
  logic   d_req;
  logic   timeout;

  assign i_req = i_cyc & i_stb;
  assign d_req = d_cyc & d_stb;

`ifdef CACHE_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] tmo_cnt_q;
  logic [CW-1:0] tmo_cnt_d;
  logic          stb_raw;

  assign stb_raw = (state_q == GRANT_I) ? i_stb :
                   (state_q == GRANT_D) ? d_stb : 1'b0;

  // Fires on the TIMEOUT_CYCLES-th stalled strobe cycle, counting the current one.
  assign timeout = stb_raw & ~mem_ack & (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == IDLE || mem_ack) begin
      tmo_cnt_d = '0;
    end else if (stb_raw) begin
      tmo_cnt_d = tmo_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          // On a tie the port that did not own the bus last wins.
          if (i_req && (!d_req || last_grant_q)) begin
            state_q      <= GRANT_I;
            last_grant_q <= 1'b0;
          end else if (d_req) begin
            state_q      <= GRANT_D;
            last_grant_q <= 1'b1;
          end
        end
        GRANT_I: if (!i_cyc || timeout) state_q <= IDLE;
        GRANT_D: if (!d_cyc || timeout) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_cyc   = 1'b0;
    mem_stb   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_ack     = 1'b0;
    i_rty     = 1'b0;
    d_ack     = 1'b0;
    d_rty     = 1'b0;
    case (state_q)
      GRANT_I: begin
        mem_cyc   = i_cyc & ~timeout;
        mem_stb   = i_stb & ~timeout;
        mem_we    = i_we;
        mem_addr  = i_addr;
        mem_wdata = i_wdata;
        i_ack     = mem_ack & i_cyc;
        i_rty     = (mem_rty & i_cyc) | timeout;
      end
      GRANT_D: begin
        mem_cyc   = d_cyc & ~timeout;
        mem_stb   = d_stb & ~timeout;
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        d_ack     = mem_ack & d_cyc;
        d_rty     = (mem_rty & d_cyc) | timeout;
      end
      default: ;
    endcase
  end

  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule
